// File: rtl/lns_pkg.sv
// Shared LNS definitions: default log word width, clamp limits, sequencer states.
package lns_pkg;

   localparam int LNS_W = 22;

   localparam logic signed [LNS_W-1:0] LOG_MAX = {1'b0, {(LNS_W-1){1'b1}}};
   localparam logic signed [LNS_W-1:0] LOG_MIN = {1'b1, {(LNS_W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } lns_state_e;

endpackage

// File: rtl/lns_mul_sat.sv
// LNS multiply: log magnitudes add with saturation to the W-bit range, signs XOR.
module lns_mul_sat
   import lns_pkg::*;
#(
   parameter int W = LNS_W
) (
   input  logic [W-1:0] i_a,
   input  logic         i_sa,
   input  logic [W-1:0] i_b,
   input  logic         i_sb,
   output logic [W-1:0] o_p,
   output logic         o_sp,
   output logic         o_sat
);

   localparam logic [W-1:0] P_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] P_MIN = {1'b1, {(W-1){1'b0}}};

   logic [W:0] w_sum;

   // Sign-extended sum; overflow shows as disagreement of the two top bits.
   always_comb begin
      w_sum = {i_a[W-1], i_a} + {i_b[W-1], i_b};
      o_sat = w_sum[W] ^ w_sum[W-1];
      o_sp  = i_sa ^ i_sb;
      if (o_sat) begin
         o_p = w_sum[W] ? P_MIN : P_MAX;
      end else begin
         o_p = w_sum[W-1:0];
      end
   end

endmodule

// File: rtl/lns_dot_sequencer.sv
// LNS dot-product sequencer: multiplies operand pairs and accumulates the
// products through the external log adder, one result per vector.
module lns_dot_sequencer
   import lns_pkg::*;
#(
   parameter int W     = LNS_W,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic             in_sa,
   input  logic [W-1:0]     in_b,
   input  logic             in_sb,
   input  logic             in_last,
   output logic [W-1:0]     add_x,
   output logic             add_sx,
   output logic [W-1:0]     add_y,
   output logic             add_sy,
   input  logic [W-1:0]     add_z,
   input  logic             add_sz,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_log,
   output logic             out_sign,
   output logic [CNT_W-1:0] out_count,
   output logic             out_sat
);

   lns_state_e       r_state;
   logic             r_first;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_last_q;
   logic [W-1:0]     r_acc;
   logic             r_sacc;
   logic [CNT_W-1:0] r_count;
   logic             r_sat;
   logic [W-1:0]     r_add_x;
   logic             r_add_sx;
   logic [W-1:0]     r_add_y;
   logic             r_add_sy;

   logic [W-1:0]     w_p;
   logic             w_sp;
   logic             w_sat;

   lns_mul_sat #(.W(W)) u_mul (
      .i_a   (in_a),
      .i_sa  (in_sa),
      .i_b   (in_b),
      .i_sb  (in_sb),
      .o_p   (w_p),
      .o_sp  (w_sp),
      .o_sat (w_sat)
   );

   // Sequencer FSM: accept pairs, run one adder cycle per non-first element, hold result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_first     <= 1'b1;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_last_q    <= 1'b0;
         r_acc       <= '0;
         r_sacc      <= 1'b0;
         r_count     <= '0;
         r_sat       <= 1'b0;
         r_add_x     <= '0;
         r_add_sx    <= 1'b0;
         r_add_y     <= '0;
         r_add_sy    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_count <= (r_count == '1) ? r_count : r_count + CNT_W'(1);
                  r_sat   <= r_sat | w_sat;
                  if (r_first) begin
                     r_acc   <= w_p;
                     r_sacc  <= w_sp;
                     r_first <= 1'b0;
                     if (in_last) begin
                        r_state     <= S_DONE;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                     end
                  end else begin
                     r_add_x    <= r_acc;
                     r_add_sx   <= r_sacc;
                     r_add_y    <= w_p;
                     r_add_sy   <= w_sp;
                     r_last_q   <= in_last;
                     r_state    <= S_ADD;
                     r_in_ready <= 1'b0;
                  end
               end
            end
            S_ADD: begin
               r_acc  <= add_z;
               r_sacc <= add_sz;
               if (r_last_q) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
               end else begin
                  r_state    <= S_IDLE;
                  r_in_ready <= 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_first     <= 1'b1;
                  r_count     <= '0;
                  r_sat       <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_first     <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_log   = r_acc;
   assign out_sign  = r_sacc;
   assign out_count = r_count;
   assign out_sat   = r_sat;
   assign add_x     = r_add_x;
   assign add_sx    = r_add_sx;
   assign add_y     = r_add_y;
   assign add_sy    = r_add_sy;

endmodule

// File: tb/tb_lns_dot_sequencer.sv
// Self-checking bench for lns_dot_sequencer with a behavioural log adder.
module tb_lns_dot_sequencer;

   localparam int W     = 22;
   localparam int CNT_W = 8;
   localparam int LMAX  = (1 << (W-1)) - 1;
   localparam int LMIN  = -(1 << (W-1));
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_a;
   logic             in_sa;
   logic [W-1:0]     in_b;
   logic             in_sb;
   logic             in_last;
   logic [W-1:0]     add_x;
   logic             add_sx;
   logic [W-1:0]     add_y;
   logic             add_sy;
   logic [W-1:0]     add_z;
   logic             add_sz;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_log;
   logic             out_sign;
   logic [CNT_W-1:0] out_count;
   logic             out_sat;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   lns_dot_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_sa     (in_sa),
      .in_b      (in_b),
      .in_sb     (in_sb),
      .in_last   (in_last),
      .add_x     (add_x),
      .add_sx    (add_sx),
      .add_y     (add_y),
      .add_sy    (add_sy),
      .add_z     (add_z),
      .add_sz    (add_sz),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_log   (out_log),
      .out_sign  (out_sign),
      .out_count (out_count),
      .out_sat   (out_sat)
   );

   typedef struct { int v; bit s; } lns_t;
   typedef struct { int a; bit sa; int b; bit sb; } pair_t;

   function automatic int clampv(int x);
      if (x > LMAX) return LMAX;
      if (x < LMIN) return LMIN;
      return x;
   endfunction

   // Behavioural log adder: larger operand dominates, +/-1 when operands are close.
   function automatic lns_t ref_add(lns_t x, lns_t y);
      lns_t r;
      int d, ad, bump;
      lns_t big;
      d    = x.v - y.v;
      ad   = (d < 0) ? -d : d;
      big  = (d >= 0) ? x : y;
      bump = (ad < 4) ? 1 : 0;
      r.s  = big.s;
      r.v  = clampv((x.s == y.s) ? big.v + bump : big.v - bump);
      return r;
   endfunction

   lns_t m_x, m_y, m_z;
   always_comb begin
      m_x.v  = $signed(add_x);
      m_x.s  = add_sx;
      m_y.v  = $signed(add_y);
      m_y.s  = add_sy;
      m_z    = ref_add(m_x, m_y);
      add_z  = W'(m_z.v);
      add_sz = m_z.s;
   end

   // Whole-vector reference: clamp each product, fold through the adder model.
   task automatic expect_vec(input pair_t q[$], output int elog, output bit esign,
                             output int ecnt, output bit esat);
      lns_t acc, p;
      int   s;
      esat = 1'b0;
      for (int i = 0; i < q.size(); i++) begin
         s   = q[i].a + q[i].b;
         p.v = clampv(s);
         p.s = q[i].sa ^ q[i].sb;
         if (p.v != s) esat = 1'b1;
         acc = (i == 0) ? p : ref_add(acc, p);
      end
      elog  = acc.v;
      esign = acc.s;
      ecnt  = (q.size() > CMAX) ? CMAX : q.size();
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send_pair(input int a, input bit sa, input int b, input bit sb, input bit last);
      int t;
      in_a     = W'(a);
      in_sa    = sa;
      in_b     = W'(b);
      in_sb    = sb;
      in_last  = last;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!in_ready) check("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int t;
      t = 0;
      while (!out_valid && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (!out_valid) check("out_valid_timeout", 0, 1);
   endtask

   task automatic check_out(input string tag, input int elog, input bit esign,
                            input int ecnt, input bit esat);
      check({tag, "_log"},   $signed(out_log), elog);
      check({tag, "_sign"},  int'(out_sign), int'(esign));
      check({tag, "_count"}, int'(out_count), ecnt);
      check({tag, "_sat"},   int'(out_sat), int'(esat));
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   typedef struct {
      int a; bit sa; int b; bit sb;
      int exp_log; bit exp_sign; bit exp_sat;
   } vec_t;

   vec_t  tbl[6];
   pair_t q[$];
   int    elog, ecnt;
   bit    esign, esat;

   initial begin
      tbl[0] = '{5,        1'b0, 3,  1'b1, 8,        1'b1, 1'b0};
      tbl[1] = '{2097151,  1'b0, 1,  1'b0, 2097151,  1'b0, 1'b1};
      tbl[2] = '{-2097152, 1'b0, -1, 1'b0, -2097152, 1'b0, 1'b1};
      tbl[3] = '{-3,       1'b1, -4, 1'b1, -7,       1'b0, 1'b0};
      tbl[4] = '{100,      1'b1, -50,1'b0, 50,       1'b1, 1'b0};
      tbl[5] = '{2097150,  1'b1, 1,  1'b1, 2097151,  1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_sa = 1'b0; in_b = '0;
      in_sb = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_log",   int'(out_log), 0);
      check("rst_out_count", int'(out_count), 0);
      check("rst_out_sat",   int'(out_sat), 0);
      check("rst_add_x",     int'(add_x), 0);
      check("rst_add_y",     int'(add_y), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Single-element vectors: result is valid one cycle after acceptance.
      for (int i = 0; i < 6; i++) begin
         send_pair(tbl[i].a, tbl[i].sa, tbl[i].b, tbl[i].sb, 1'b1);
         check("single_latency", int'(out_valid), 1);
         check_out("single", tbl[i].exp_log, tbl[i].exp_sign, 1, tbl[i].exp_sat);
         pop();
      end

      // Two-element vector: the ADD cycle presents acc and product to the adder.
      send_pair(5, 1'b0, 3, 1'b0, 1'b0);
      check("two_first_ready", int'(in_ready), 1);
      send_pair(4, 1'b0, 4, 1'b0, 1'b1);
      check("two_add_ready", int'(in_ready), 0);
      check("two_add_valid", int'(out_valid), 0);
      check("two_add_x", $signed(add_x), 8);
      check("two_add_y", $signed(add_y), 8);
      @(posedge clk); #1;
      check("two_latency", int'(out_valid), 1);
      check_out("two", 9, 1'b0, 2, 1'b0);
      pop();

      // Backpressure in DONE, with a competing input pair that must not be taken.
      send_pair(10, 1'b0, 20, 1'b0, 1'b1);
      in_a = W'(7); in_b = W'(7); in_last = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", int'(out_valid), 1);
         check("bp_in_ready", int'(in_ready), 0);
         check_out("bp", 30, 1'b0, 1, 1'b0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      pop();
      check("bp_release_valid", int'(out_valid), 0);
      check("bp_release_count", int'(out_count), 0);
      check("bp_release_ready", int'(in_ready), 1);

      // Reset during ADD discards the partial vector.
      send_pair(1, 1'b0, 1, 1'b0, 1'b0);
      send_pair(2, 1'b0, 2, 1'b0, 1'b0);
      check("rstadd_in_add", int'(in_ready), 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rstadd_ready", int'(in_ready), 1);
      check("rstadd_valid", int'(out_valid), 0);
      send_pair(2, 1'b0, 2, 1'b0, 1'b1);
      wait_valid();
      check_out("rstadd_fresh", 4, 1'b0, 1, 1'b0);
      pop();

      // Element counter saturates at all-ones.
      q.delete();
      for (int i = 0; i < 260; i++) begin
         q.push_back('{1, 1'b0, 1, 1'b0});
         send_pair(1, 1'b0, 1, 1'b0, (i == 259));
      end
      wait_valid();
      expect_vec(q, elog, esign, ecnt, esat);
      check_out("cntsat", elog, esign, ecnt, esat);
      pop();

      // Randomised vectors with idle gaps and result backpressure.
      for (int v = 0; v < 40; v++) begin
         int n;
         q.delete();
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) begin
            pair_t pr;
            if ($urandom_range(0, 7) == 0) begin
               pr.a = ($urandom_range(0, 1) != 0) ? LMAX - int'($urandom_range(0, 3))
                                                   : LMIN + int'($urandom_range(0, 3));
               pr.b = int'($urandom_range(0, 8)) - 4;
            end else begin
               pr.a = int'($urandom_range(0, 2000)) - 1000;
               pr.b = int'($urandom_range(0, 2000)) - 1000;
            end
            pr.sa = 1'($urandom_range(0, 1));
            pr.sb = 1'($urandom_range(0, 1));
            q.push_back(pr);
         end
         for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1;
            end
            send_pair(q[i].a, q[i].sa, q[i].b, q[i].sb, (i == n-1));
         end
         wait_valid();
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         expect_vec(q, elog, esign, ecnt, esat);
         check_out("rand", elog, esign, ecnt, esat);
         pop();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lns_dot_sequencer.md
Name: lns_dot_sequencer

Overview:
- Upstream feeder for the log-domain adder; consumes its result.
- Accepts a stream of sign/log operand pairs and forms each LNS product: log sum with saturation, sign XOR.
- Accumulates the products through the external combinational log adder and emits one sign/log dot-product per vector.
- Sits between the operand buffer (valid/ready) and the result sink (valid/ready).

Parameters:
- W, 22, log word width; signed two's-complement fixed point, matching the adder's bit_size.
- CNT_W, 8, width of the per-vector element counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept a pair this cycle
- in_a  in  W  log magnitude of operand A, signed
- in_sa  in  1  sign of A
- in_b  in  W  log magnitude of operand B, signed
- in_sb  in  1  sign of B
- in_last  in  1  pair is the final element of the vector
- add_x  out  W  adder operand X (accumulator), registered
- add_sx  out  1  adder sign X, registered
- add_y  out  W  adder operand Y (product), registered
- add_sy  out  1  adder sign Y, registered
- add_z  in  W  adder result, combinational from add_x/add_y
- add_sz  in  1  adder result sign
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- out_log  out  W  accumulated log magnitude
- out_sign  out  1  accumulated sign
- out_count  out  CNT_W  elements in vector, saturating at all-ones
- out_sat  out  1  sticky: any product saturated in this vector

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - state=IDLE, first=1, in_ready=1, out_valid=0.
  - out_log, out_sign, out_count, out_sat = 0.
  - add_x, add_y, add_sx, add_sy = 0.
- Product:
  - p = in_a + in_b, computed at W+1 bits.
  - Clamp to [-2^(W-1), 2^(W-1)-1]; set sat flag if clamped.
  - sp = in_sa ^ in_sb.
- IDLE (in_ready=1). On in_valid, i.e. handshake:
  - count increments, saturating.
  - out_sat |= sat.
  - If first=1:
    - acc<=p, sacc<=sp, first<=0.
    - in_last=1 -> DONE; else stay in IDLE.
  - If first=0:
    - add_x<=acc, add_sx<=sacc, add_y<=p, add_sy<=sp.
    - Latch in_last into last_q; go to ADD.
- ADD (in_ready=0), exactly 1 cycle:
  - acc<=add_z, sacc<=add_sz.
  - last_q=1 -> DONE; else IDLE.
- DONE:
  - out_valid=1; out_log/out_sign/out_count/out_sat are stable while out_ready=0.
  - in_ready=0.
  - On out_ready: next cycle state=IDLE, out_valid=0, first=1, count=0, out_sat=0.
- Latency:
  - First element: 1 cycle per pair.
  - Each later element: 2 cycles per pair.
  - Last acceptance to out_valid: 1 cycle (first-element vector) or 2 cycles (otherwise).
- Out-of-band: in_valid=0 in IDLE holds all state; add_* hold their last values.
- Count wrap: count stops at 2^CNT_W-1 and never wraps.
- Reset mid-operation (ADD or DONE):
  - Discards the partial vector.
  - Next cycle: IDLE, in_ready=1, out_valid=0.
- Simultaneous events: in DONE, in_valid is ignored and not accepted, because in_ready=0.
- The block makes no zero-value encoding; the upstream buffer never issues zero operands.

Decomposition:
- Shared package (lns_pkg) holds:
  - W default (22).
  - LOG_MAX = 2^(W-1)-1 and LOG_MIN = -2^(W-1) constants.
  - State encoding: IDLE, ADD, DONE.
- Sub-module lns_mul_sat: combinational product with clamp and sat flag. Reused by later LNS multiply stages.
- The log adder stays external; the bench uses a behavioural adder model on the add_* ports.

Test Plan:
- Single-element vector: a=5, sa=0, b=3, sb=1, last=1 -> after 1 cycle out_valid=1, out_log=8, out_sign=1, out_count=1, out_sat=0.
- Two-element vector: (5,3), then (4,4,last), all signs 0.
  - add_x=8, add_y=8 are driven in the ADD cycle.
  - out_log equals the model's add_z for (8,8); out_count=2.
  - in_ready=0 during ADD.
- Positive saturation: a=2097151, b=1, last -> out_log=2097151, out_sat=1.
- Negative saturation: a=-2097152, b=-1, last -> out_log=-2097152, out_sat=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - Outputs are constant and in_ready=0 throughout.
  - After out_ready=1: next cycle IDLE, out_valid=0, out_count=0.
- Reset asserted during ADD of a 3-element vector -> next cycle in_ready=1, out_valid=0. A fresh single-element vector (2,2) then yields out_log=4, out_count=1.
